// File: rtl/freq_tuner_pkg.sv
// Shared constants, state encoding and clamped-step helper for the SWIPT frequency tuner.
// The step helper works one bit wider than the frequency word so overflow and underflow are visible.
package freq_tuner_pkg;

  localparam int FREQ_W       = 20;
  localparam int FREQ_DEFAULT = 40000;
  localparam int FREQ_MIN     = 20000;
  localparam int FREQ_MAX     = 80000;

  localparam logic [FREQ_W:0] FREQ_MIN_WIDE = (FREQ_W+1)'(FREQ_MIN);
  localparam logic [FREQ_W:0] FREQ_MAX_WIDE = (FREQ_W+1)'(FREQ_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } tuner_state_e;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic              at_limit;
  } step_result_t;

  // Up steps saturate at FREQ_MAX and down steps at FREQ_MIN; the word never wraps.
  function automatic step_result_t clamp_step(input logic [FREQ_W-1:0] cur,
                                              input logic [FREQ_W-1:0] delta,
                                              input logic              up);
    logic [FREQ_W:0] wide_cur;
    logic [FREQ_W:0] wide_delta;
    logic [FREQ_W:0] sum;
    logic [FREQ_W:0] floor_chk;
    step_result_t    res;
    wide_cur   = {1'b0, cur};
    wide_delta = {1'b0, delta};
    sum        = wide_cur + wide_delta;
    floor_chk  = FREQ_MIN_WIDE + wide_delta;
    if (up) begin
      if (sum > FREQ_MAX_WIDE) begin
        res.freq     = FREQ_W'(FREQ_MAX);
        res.at_limit = 1'b1;
      end else begin
        res.freq     = sum[FREQ_W-1:0];
        res.at_limit = 1'b0;
      end
    end else begin
      if (wide_cur < floor_chk) begin
        res.freq     = FREQ_W'(FREQ_MIN);
        res.at_limit = 1'b1;
      end else begin
        res.freq     = cur - delta;
        res.at_limit = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/freq_tuner_if.sv
// Bundle between the Freq search / heartbeat side (master) and the tuner (slave),
// including the drive-frequency and status outputs toward SwiptOut.
interface freq_tuner_if;
  import freq_tuner_pkg::*;

  logic              swipt_alive;
  logic              freq_ready;
  logic              freq_set_up_down;
  logic              freq_opt;
  logic [FREQ_W-1:0] delta_freq;
  logic              power_opt;
  logic              retune;

  logic [FREQ_W-1:0] freq;
  logic              freq_settled;
  logic              freq_locked;
  logic              at_limit;
  logic              data_go;

  modport master (
    output swipt_alive, freq_ready, freq_set_up_down, freq_opt, delta_freq, power_opt, retune,
    input  freq, freq_settled, freq_locked, at_limit, data_go
  );

  modport slave (
    input  swipt_alive, freq_ready, freq_set_up_down, freq_opt, delta_freq, power_opt, retune,
    output freq, freq_settled, freq_locked, at_limit, data_go
  );
endinterface

// File: rtl/freq_tuner_settle_timer.sv
// Down-counter that times the analog settle window after each applied frequency step.
// done is high on the last counting cycle; idle is high whenever no window is running.
module settle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             done,
  output logic             idle
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1));
  assign idle = (cnt == '0);

endmodule

// File: rtl/freq_tuner.sv
// SWIPT drive-frequency owner: applies clamped steps from the search algorithm, holds off
// during settle windows, and locks on freq_opt or on direction hunting.
module freq_tuner
  import freq_tuner_pkg::*;
#(
  parameter int SETTLE_CYC = 1000,
  parameter int CNT_W      = 16,
  parameter int MAX_REV    = 4
) (
  input logic         clk,
  input logic         nrst,
  freq_tuner_if.slave bus
);

  localparam int REV_W = $clog2(MAX_REV + 1);
  localparam logic [REV_W-1:0] REV_LIMIT = REV_W'(MAX_REV);

  tuner_state_e      state;
  logic [FREQ_W-1:0] freq_q;
  logic [REV_W-1:0]  rev_cnt;
  logic              last_dir;
  logic              at_limit_q;
  logic              locked_q;
  logic              data_go_q;

  step_result_t      step;
  logic              apply_step;
  logic              timer_done;
  logic              timer_idle;

  // NOTE: every signal driven in always_comb gets a value on every path to avoid latches.
  always_comb begin
    step       = clamp_step(freq_q, bus.delta_freq, bus.freq_set_up_down);
    apply_step = 1'b0;
    if (bus.swipt_alive && state == ST_TRACK && !bus.freq_opt &&
        bus.freq_ready && bus.delta_freq != '0) begin
      apply_step = 1'b1;
    end
  end

  settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (apply_step),
    .clear    (!bus.swipt_alive),
    .load_val (CNT_W'(SETTLE_CYC)),
    .done     (timer_done),
    .idle     (timer_idle)
  );

  // NOTE: only the small control registers are reset; there is no memory here to worry about.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      freq_q     <= FREQ_W'(FREQ_DEFAULT);
      rev_cnt    <= '0;
      last_dir   <= 1'b1;
      at_limit_q <= 1'b0;
      locked_q   <= 1'b0;
      data_go_q  <= 1'b0;
    end else if (!bus.swipt_alive) begin
      // Losing the receiver overrides everything; frequency and last direction are kept.
      state      <= ST_IDLE;
      rev_cnt    <= '0;
      at_limit_q <= 1'b0;
      locked_q   <= 1'b0;
      data_go_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: state <= ST_TRACK;
        ST_TRACK: begin
          if (bus.freq_opt) begin
            state    <= ST_LOCKED;
            locked_q <= 1'b1;
          end else if (apply_step) begin
            freq_q     <= step.freq;
            at_limit_q <= step.at_limit;
            last_dir   <= bus.freq_set_up_down;
            if (bus.freq_set_up_down != last_dir && rev_cnt != REV_LIMIT) begin
              rev_cnt <= rev_cnt + 1'b1;
            end
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer_done) begin
            if (rev_cnt == REV_LIMIT) begin
              state    <= ST_LOCKED;
              locked_q <= 1'b1;
            end else begin
              state <= ST_TRACK;
            end
          end
        end
        ST_LOCKED: begin
          if (bus.retune) begin
            state     <= ST_TRACK;
            rev_cnt   <= '0;
            locked_q  <= 1'b0;
            data_go_q <= 1'b0;
          end else begin
            data_go_q <= bus.power_opt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.freq         = freq_q;
  assign bus.freq_settled = timer_idle;
  assign bus.freq_locked  = locked_q;
  assign bus.at_limit     = at_limit_q;
  assign bus.data_go      = data_go_q;

endmodule

// File: tb/tb_freq_tuner.sv
// Self-checking bench for freq_tuner: directed scenarios plus randomized steps compared
// against an integer model of the clamp, settle-window and hunting-lock rules.
module tb_freq_tuner;
  import freq_tuner_pkg::*;

  localparam int SETTLE = 10;
  localparam int MAXREV = 4;

  logic clk = 1'b0;
  logic nrst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state.
  int m_freq;
  bit m_last_dir;
  int m_rev;
  bit m_at_limit;
  bit m_locked;

  freq_tuner_if bus ();

  freq_tuner #(.SETTLE_CYC(SETTLE), .CNT_W(16), .MAX_REV(MAXREV)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_freq     = 40000;
    m_last_dir = 1'b1;
    m_rev      = 0;
    m_at_limit = 1'b0;
    m_locked   = 1'b0;
  endtask

  // One step request in TRACK (or LOCKED), then wait out the settle window.
  task automatic do_step(input bit up, input int delta, input string tag);
    int exp_f;
    bit exp_lim;
    bit ignored;
    int n;
    ignored = m_locked || (delta == 0);
    exp_f   = m_freq;
    exp_lim = m_at_limit;
    if (!ignored) begin
      if (up) begin
        if (m_freq + delta > 80000) begin exp_f = 80000; exp_lim = 1'b1; end
        else begin exp_f = m_freq + delta; exp_lim = 1'b0; end
      end else begin
        if (m_freq < 20000 + delta) begin exp_f = 20000; exp_lim = 1'b1; end
        else begin exp_f = m_freq - delta; exp_lim = 1'b0; end
      end
    end
    bus.freq_ready       = 1'b1;
    bus.freq_set_up_down = up;
    bus.delta_freq       = FREQ_W'(delta);
    tick();
    bus.freq_ready       = 1'b0;
    bus.freq_set_up_down = 1'($urandom);
    bus.delta_freq       = FREQ_W'($urandom);
    n_checks++;
    if (bus.freq !== FREQ_W'(exp_f)) begin
      n_fail++;
      $display("FAIL %s freq: got %0d expected %0d", tag, bus.freq, exp_f);
    end
    n_checks++;
    if (bus.at_limit !== exp_lim) begin
      n_fail++;
      $display("FAIL %s at_limit: got %b expected %b", tag, bus.at_limit, exp_lim);
    end
    n_checks++;
    if (bus.freq_settled !== ignored) begin
      n_fail++;
      $display("FAIL %s settled_after_req: got %b expected %b", tag, bus.freq_settled, ignored);
    end
    if (!ignored) begin
      n = 0;
      while (bus.freq_settled !== 1'b1 && n < 100) begin
        n++;
        tick();
      end
      n_checks++;
      if (n != SETTLE) begin
        n_fail++;
        $display("FAIL %s window_len: got %0d expected %0d", tag, n, SETTLE);
      end
      if (up != m_last_dir) m_rev++;
      m_last_dir = up;
      m_freq     = exp_f;
      m_at_limit = exp_lim;
      m_locked   = (m_rev >= MAXREV);
      n_checks++;
      if (bus.freq !== FREQ_W'(m_freq)) begin
        n_fail++;
        $display("FAIL %s freq_after_window: got %0d expected %0d", tag, bus.freq, m_freq);
      end
    end
    n_checks++;
    if (bus.freq_locked !== m_locked) begin
      n_fail++;
      $display("FAIL %s locked: got %b expected %b", tag, bus.freq_locked, m_locked);
    end
  endtask

  task automatic do_retune(input string tag);
    bus.retune = 1'b1;
    tick();
    bus.retune = 1'b0;
    m_rev    = 0;
    m_locked = 1'b0;
    n_checks++;
    if (bus.freq_locked !== 1'b0 || bus.data_go !== 1'b0) begin
      n_fail++;
      $display("FAIL %s retune: locked=%b data_go=%b expected 0 0", tag, bus.freq_locked, bus.data_go);
    end
  endtask

  task automatic drop_alive(input string tag);
    bus.swipt_alive = 1'b0;
    tick();
    m_rev      = 0;
    m_at_limit = 1'b0;
    m_locked   = 1'b0;
    n_checks++;
    if (bus.freq !== FREQ_W'(m_freq) || bus.freq_settled !== 1'b1 || bus.freq_locked !== 1'b0 ||
        bus.at_limit !== 1'b0 || bus.data_go !== 1'b0) begin
      n_fail++;
      $display("FAIL %s alive_drop: freq=%0d settled=%b locked=%b lim=%b go=%b expected %0d 1 0 0 0",
               tag, bus.freq, bus.freq_settled, bus.freq_locked, bus.at_limit, bus.data_go, m_freq);
    end
    bus.swipt_alive = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.swipt_alive = 1'b0;
    repeat (5) tick();
    nrst = 1'b1;
    bus.swipt_alive = 1'b1;
    tick();
    model_reset();
    n_checks++;
    if (bus.freq !== FREQ_W'(40000) || bus.freq_settled !== 1'b1 || bus.freq_locked !== 1'b0 ||
        bus.at_limit !== 1'b0 || bus.data_go !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: freq=%0d settled=%b locked=%b lim=%b go=%b expected 40000 1 0 0 0",
               bus.freq, bus.freq_settled, bus.freq_locked, bus.at_limit, bus.data_go);
    end
  endtask

  task automatic test_step_and_drop();
    int n;
    bus.freq_ready       = 1'b1;
    bus.freq_set_up_down = 1'b1;
    bus.delta_freq       = FREQ_W'(100);
    tick();
    bus.freq_ready = 1'b0;
    n_checks++;
    if (bus.freq !== FREQ_W'(40100) || bus.freq_settled !== 1'b0) begin
      n_fail++;
      $display("FAIL first_step: freq=%0d settled=%b expected 40100 0", bus.freq, bus.freq_settled);
    end
    n = 0;
    while (bus.freq_settled !== 1'b1 && n < 100) begin
      n++;
      if (n == 3) begin
        bus.freq_ready = 1'b1;
        bus.delta_freq = FREQ_W'(500);
      end
      tick();
      bus.freq_ready = 1'b0;
    end
    n_checks++;
    if (n != SETTLE) begin
      n_fail++;
      $display("FAIL first_window_len: got %0d expected %0d", n, SETTLE);
    end
    n_checks++;
    if (bus.freq !== FREQ_W'(40100)) begin
      n_fail++;
      $display("FAIL dropped_request: freq=%0d expected 40100", bus.freq);
    end
    m_freq = 40100;
  endtask

  task automatic test_clamp();
    drop_alive("clamp_prep");
    do_step(1'b1, 79950 - m_freq, "to_79950");
    do_step(1'b1, 100, "clamp_max");
    do_step(1'b0, 80000 - 20050, "to_20050");
    do_step(1'b0, 100, "clamp_min");
    do_step(1'b1, 100, "up_from_min");
    do_step(1'b0, 100, "exact_min_no_clamp");
    drop_alive("clamp_done");
    do_step(1'b1, 80000 - m_freq, "exact_max_no_clamp");
    drop_alive("clamp_done2");
  endtask

  task automatic test_hunting();
    do_step(1'b0, 30000, "hunt_center");
    drop_alive("hunt_prep");
    for (int i = 0; i < 2 * MAXREV; i++) begin
      do_step(i[0] ? 1'b0 : 1'b1, 100, "hunt");
      if (m_locked) break;
    end
    n_checks++;
    if (bus.freq_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL hunt_lock: locked=%b expected 1", bus.freq_locked);
    end
    do_step(1'b1, 700, "frozen");
    do_retune("hunt");
  endtask

  task automatic test_opt_lock();
    bus.freq_opt         = 1'b1;
    bus.freq_ready       = 1'b1;
    bus.freq_set_up_down = 1'b1;
    bus.delta_freq       = FREQ_W'(300);
    tick();
    bus.freq_opt   = 1'b0;
    bus.freq_ready = 1'b0;
    m_locked = 1'b1;
    n_checks++;
    if (bus.freq_locked !== 1'b1 || bus.freq !== FREQ_W'(m_freq) || bus.freq_settled !== 1'b1) begin
      n_fail++;
      $display("FAIL opt_lock: locked=%b freq=%0d settled=%b expected 1 %0d 1",
               bus.freq_locked, bus.freq, bus.freq_settled, m_freq);
    end
    bus.power_opt = 1'b1;
    #2;
    n_checks++;
    if (bus.data_go !== 1'b0) begin
      n_fail++;
      $display("FAIL data_go_lag: got %b expected 0", bus.data_go);
    end
    tick();
    n_checks++;
    if (bus.data_go !== 1'b1) begin
      n_fail++;
      $display("FAIL data_go_set: got %b expected 1", bus.data_go);
    end
    bus.power_opt = 1'b0;
    tick();
    n_checks++;
    if (bus.data_go !== 1'b0) begin
      n_fail++;
      $display("FAIL data_go_clear: got %b expected 0", bus.data_go);
    end
    bus.power_opt = 1'b1;
    tick();
    do_retune("opt");
    bus.power_opt = 1'b0;
    do_step(1'b1, 250, "after_retune");
  endtask

  task automatic test_alive_drop();
    bus.freq_ready       = 1'b1;
    bus.freq_set_up_down = 1'b1;
    bus.delta_freq       = FREQ_W'(100);
    tick();
    bus.freq_ready = 1'b0;
    if (m_last_dir != 1'b1) m_rev++;
    m_last_dir = 1'b1;
    m_freq     = m_freq + 100;
    repeat (3) tick();
    bus.swipt_alive = 1'b0;
    bus.freq_ready  = 1'b1;
    bus.delta_freq  = FREQ_W'(900);
    tick();
    bus.freq_ready = 1'b0;
    m_rev      = 0;
    m_at_limit = 1'b0;
    n_checks++;
    if (bus.freq !== FREQ_W'(m_freq) || bus.freq_settled !== 1'b1 || bus.at_limit !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_settle_drop: freq=%0d settled=%b lim=%b expected %0d 1 0",
               bus.freq, bus.freq_settled, bus.at_limit, m_freq);
    end
    bus.swipt_alive = 1'b1;
    tick();
    do_step(1'b0, 100, "after_restore");
  endtask

  task automatic test_reset_mid_step();
    bus.freq_ready       = 1'b1;
    bus.freq_set_up_down = 1'b0;
    bus.delta_freq       = FREQ_W'(5000);
    tick();
    bus.freq_ready = 1'b0;
    tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    model_reset();
    n_checks++;
    if (bus.freq !== FREQ_W'(40000) || bus.freq_settled !== 1'b1 || bus.at_limit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_step: freq=%0d settled=%b lim=%b expected 40000 1 0",
               bus.freq, bus.freq_settled, bus.at_limit);
    end
    tick();
  endtask

  task automatic test_random();
    int delta;
    bit up;
    for (int i = 0; i < 60; i++) begin
      up = 1'($urandom);
      case ($urandom % 4)
        0:       delta = 0;
        1:       delta = $urandom_range(1, 500);
        2:       delta = $urandom_range(1, 70000);
        default: delta = $urandom_range(1, (1 << 20) - 1);
      endcase
      do_step(up, delta, "random");
      if (m_locked) do_retune("random");
      if ($urandom % 10 == 0) drop_alive("random");
    end
  endtask

  initial begin
    nrst                 = 1'b0;
    bus.swipt_alive      = 1'b0;
    bus.freq_ready       = 1'b0;
    bus.freq_set_up_down = 1'b0;
    bus.freq_opt         = 1'b0;
    bus.delta_freq       = '0;
    bus.power_opt        = 1'b0;
    bus.retune           = 1'b0;
    model_reset();
    test_reset();
    test_step_and_drop();
    test_clamp();
    test_hunting();
    test_opt_lock();
    test_alive_drop();
    test_reset_mid_step();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
